// File: rtl/pixel_plotter_pkg.sv
// Shared screen geometry, FSM state encoding and framebuffer address helper.
// Pure definitions: no latency or backpressure of its own.
package pixel_plotter_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int FB_ADDR_W = 15;
    localparam int FB_SIZE   = 19200;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } coord_t;

    // y*160 + x built from shifts so no multiplier is inferred.
    function automatic logic [FB_ADDR_W-1:0] pix_addr(input coord_t c);
        logic [FB_ADDR_W-1:0] yw;
        logic [FB_ADDR_W-1:0] xw;
        yw = FB_ADDR_W'(c.y);
        xw = FB_ADDR_W'(c.x);
        return (yw << 7) + (yw << 5) + xw;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Generic first-word fall-through queue with synchronous flush.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push is taken when not full, or when full with a simultaneous pop.
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             RESET,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge Clk) begin
        if (RESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge Clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/pixel_plotter.sv
// Queues pixel writes and streams them, or a full-screen clear, to a framebuffer port (PLOT_CLIP_EN: drop off-screen pixels instead of clamping).
// Latency: pixel accepted at edge k into an idle empty queue is written at edge k+1; clear takes 19200 cycles.
// Backpressure: in_ready low when queue full, while clearing, or while clear_req is asserted.
module pixel_plotter
    import pixel_plotter_pkg::*;
#(
    parameter int COLOR_W    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [X_W-1:0]       in_x,
    input  logic [Y_W-1:0]       in_y,
    input  logic [COLOR_W-1:0]   in_color,
    input  logic                 clear_req,
    input  logic [COLOR_W-1:0]   clear_color,
    output logic                 busy,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOR_W-1:0]   fb_data
);

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        coord_t             pos;
    } pix_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [FB_ADDR_W-1:0]   clr_cnt;
    logic [COLOR_W-1:0]     clr_color_q;
    logic                   clear_go;
    logic                   accept;
    logic                   q_push;
    logic                   q_pop;
    logic                   q_full;
    logic                   q_empty;
    pix_t                   q_in;
    pix_t                   q_out;

    assign clear_go = clear_req && (state != CLEAR);
    assign accept   = in_valid && in_ready;

`ifdef PLOT_CLIP_EN
    always_comb begin
        q_in       = '0;
        q_in.color = in_color;
        q_in.pos.x = in_x;
        q_in.pos.y = in_y;
        q_push     = accept && (in_x <= X_W'(SCREEN_W - 1)) && (in_y <= Y_W'(SCREEN_H - 1));
    end
`else
    always_comb begin
        q_in       = '0;
        q_in.color = in_color;
        q_in.pos.x = (in_x > X_W'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : in_x;
        q_in.pos.y = (in_y > Y_W'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : in_y;
        q_push     = accept;
    end
`endif

    pixel_fifo #(
        .WIDTH (COLOR_W + X_W + Y_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .RESET    (RESET),
        .flush    (clear_go),
        .push     (q_push),
        .push_dat (q_in),
        .pop      (q_pop),
        .pop_dat  (q_out),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge Clk) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (clear_go) state_nxt = CLEAR;
                     else if (!q_empty) state_nxt = DRAW;
            DRAW:    if (clear_go) state_nxt = CLEAR;
                     else if (q_empty) state_nxt = IDLE;
            CLEAR:   if (clr_cnt == FB_ADDR_W'(FB_SIZE - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Popping is allowed from IDLE as well so a lone pixel skips the IDLE->DRAW cycle.
    always_comb begin
        in_ready = !RESET && !q_full && (state != CLEAR) && !clear_req;
        busy     = !RESET && (!q_empty || (state == CLEAR));
        q_pop    = !RESET && !q_empty && (state != CLEAR) && !clear_req;
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            clr_cnt     <= '0;
            clr_color_q <= '0;
        end else begin
            fb_we <= 1'b0;
            if (clear_go) begin
                clr_cnt     <= '0;
                clr_color_q <= clear_color;
            end else if (state == CLEAR) begin
                fb_we   <= 1'b1;
                fb_addr <= clr_cnt;
                fb_data <= clr_color_q;
                clr_cnt <= clr_cnt + 1'b1;
            end else if (q_pop) begin
                fb_we   <= 1'b1;
                fb_addr <= pix_addr(q_out.pos);
                fb_data <= q_out.color;
            end
        end
    end

endmodule

// File: doc/pixel_plotter.md
PIXEL_PLOTTER -- requirements
Module: pixel_plotter

Interface
REQ-001 Parameter COLOR_W, default 3, SHALL set the pixel colour width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the pixel queue depth; it SHALL be a power of two and at least 2.
REQ-003 Clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1: synchronous, active-high reset.
REQ-005 in_valid  in  1: pixel request valid.
REQ-006 in_ready  out  1: plotter can accept a pixel.
REQ-007 in_x  in  8 / in_y  in  7 / in_color  in  COLOR_W: pixel column, row and colour.
REQ-008 clear_req  in  1 / clear_color  in  COLOR_W: single-cycle clear-screen command and its fill colour.
REQ-009 busy  out  1: high while the queue is non-empty or a clear is in progress.
REQ-010 fb_we  out  1 / fb_addr  out  15 / fb_data  out  COLOR_W: registered framebuffer write port.

Function
REQ-011 A pixel SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-012 in_ready SHALL equal (queue not full) AND (state != CLEAR) AND (NOT clear_req).
REQ-013 in_valid with in_ready low SHALL be ignored; the source SHALL hold the request until accepted.
REQ-014 The FSM SHALL have states IDLE, DRAW and CLEAR.
REQ-015 Transitions: IDLE->DRAW on queue non-empty; DRAW->IDLE on queue empty after a pop; any state->CLEAR on clear_req; CLEAR->IDLE after the last address is written.
REQ-016 In DRAW the block SHALL pop one queue entry per cycle and register fb_we=1, fb_addr=y*160+x and fb_data=colour.
REQ-017 Address arithmetic SHALL be (y<<7)+(y<<5)+x, computed at 15 bits.
REQ-018 Latency: a pixel accepted at edge k into an empty queue while in IDLE SHALL appear on the fb port registered at edge k+1 (first-word fall-through queue).
REQ-019 The queue SHALL sustain one push and one pop in the same cycle at any fill level, including full.
REQ-020 On clear_req the queue SHALL be flushed, and any push in that cycle SHALL be blocked.
REQ-021 CLEAR SHALL write clear_color, latched when clear_req is accepted, to addresses 0..19199 ascending, one per cycle, taking exactly 19200 cycles.
REQ-022 clear_req while in CLEAR SHALL be ignored.
REQ-023 fb_we SHALL be low in every cycle without a write.
REQ-024 When no write occurs, fb_addr and fb_data SHALL hold their last values.

Reset
REQ-025 While RESET is high: state=IDLE; queue empty; in_ready=0; busy=0; fb_we=0; fb_addr=0; fb_data=0; clear counter=0.
REQ-026 RESET asserted mid-DRAW or mid-CLEAR SHALL abort the operation with no further fb writes.
REQ-027 in_ready SHALL rise in the first cycle after RESET deasserts.

Configuration
REQ-028 Macro PLOT_CLIP_EN SHALL select the out-of-range coordinate policy.
REQ-029 With PLOT_CLIP_EN defined, a pixel with x>159 or y>119 SHALL be accepted, but neither queued nor written.
REQ-030 Without PLOT_CLIP_EN, an out-of-range x SHALL be clamped to 159 and an out-of-range y to 119 before queuing.

Structure
REQ-031 A shared package SHALL hold SCREEN_W=160, SCREEN_H=120, FB_ADDR_W=15, FB_SIZE=19200 and the state enum typedef.
REQ-032 The queue SHALL be a sub-module pixel_fifo, parameterised by width and depth, with push/pop/full/empty signals.

Verification
REQ-033 Pixel (x=3, y=2, c=5) accepted while idle -> next cycle fb_we=1, fb_addr=323, fb_data=5; busy falls afterwards.
REQ-034 Five back-to-back pixels with FIFO_DEPTH=4 and the drain running -> no loss; in_ready never drops; addresses are written in order.
REQ-035 clear_req with clear_color=2 while 3 pixels are queued -> queue flushed; fb writes addr 0..19199 with data 2; busy is high for 19200 cycles, then in_ready=1.
REQ-036 in_valid and clear_req in the same cycle -> pixel not accepted; clear starts.
REQ-037 Pixel (x=200, y=130): with PLOT_CLIP_EN -> no fb_we; without it -> fb_addr=19199.
REQ-038 RESET pulsed at clear address 500 -> fb_we=0 from the next edge; state=IDLE; no further clear writes.
